// File: rtl/motor_pwm_generator_if.sv
// Bus between the current controller and the PWM stage: duty command in, gate pair and
// period information out. Clock and reset stay outside as plain ports.
interface motor_pwm_generator_if;
    logic        Enable;
    logic [11:0] DutyCycle;
    logic        HighSide;
    logic        LowSide;
    logic        PeriodStart;
    logic [11:0] DutyLatched;

    // Controller side: issues the command, observes the gate pair.
    modport master (
        output Enable,
        output DutyCycle,
        input  HighSide,
        input  LowSide,
        input  PeriodStart,
        input  DutyLatched
    );

    // PWM stage side.
    modport slave (
        input  Enable,
        input  DutyCycle,
        output HighSide,
        output LowSide,
        output PeriodStart,
        output DutyLatched
    );
endinterface

// File: rtl/motor_pwm_generator.sv
// Complementary half-bridge PWM with dead-time insertion. The duty command is
// double-buffered and only takes effect at period boundaries. Gate outputs come from
// flops decoded off the registered FSM state, so no input reaches a gate pin
// combinationally.
module motor_pwm_generator #(
    parameter int unsigned CounterMax = 4095,
    parameter int unsigned DeadTime   = 8
) (
    input  logic                  PwmClock,
    input  logic                  ResetN,
    motor_pwm_generator_if.slave  pwmBus
);

    localparam logic [11:0] CountLast = 12'(CounterMax - 1);
    localparam logic [7:0]  DeadLoad  = 8'(DeadTime - 1);

    typedef enum logic [2:0] {
        StIdle,
        StHigh,
        StLow,
        StDeadHl,
        StDeadLh
    } gateStateT;

    logic [11:0] counterQ;
    logic [11:0] counterD;
    logic [11:0] dutyLatchedQ;
    logic        runQ;
    logic        periodStartQ;
    logic        periodWrap;
    logic        rawCompare;

    gateStateT   stateQ;
    logic [7:0]  deadCountQ;
    logic        highSideQ;
    logic        lowSideQ;

    // runQ is low on the first enabled edge, which holds the counter at 0 for one more
    // edge so the first enabled cycle shows counter 0 together with PeriodStart.
    assign periodWrap = pwmBus.Enable && runQ && (counterQ == CountLast);

    // Next period count: held at 0 while stopped or entering run, else wrapping increment.
    always_comb begin
        counterD = '0;
        if (pwmBus.Enable && runQ && !periodWrap) begin
            counterD = counterQ + 12'd1;
        end
    end

    // Duty at or above CounterMax never drops out of the compare, giving a 100% clamp.
    assign rawCompare = (counterQ < dutyLatchedQ);

    // Period counter, duty double-buffer and period strobe.
    always_ff @(posedge PwmClock) begin
        if (!ResetN) begin
            counterQ     <= '0;
            dutyLatchedQ <= '0;
            runQ         <= 1'b0;
            periodStartQ <= 1'b0;
        end else begin
            counterQ     <= counterD;
            runQ         <= pwmBus.Enable;
            periodStartQ <= pwmBus.Enable && (counterD == 12'd0);
            if (!pwmBus.Enable || periodWrap) begin
                dutyLatchedQ <= pwmBus.DutyCycle;
            end
        end
    end

    // Gate FSM with dead-time counter; gate flops decode the current state, forced off
    // immediately when Enable drops so turn-off does not wait for the state update.
    always_ff @(posedge PwmClock) begin
        if (!ResetN) begin
            stateQ     <= StIdle;
            deadCountQ <= '0;
            highSideQ  <= 1'b0;
            lowSideQ   <= 1'b0;
        end else begin
            highSideQ <= pwmBus.Enable && (stateQ == StHigh);
            lowSideQ  <= pwmBus.Enable && (stateQ == StLow);
            if (!pwmBus.Enable) begin
                stateQ <= StIdle;
            end else begin
                case (stateQ)
                    StIdle: begin
                        // Both gates already off, so no dead time on entry.
                        if (runQ) begin
                            stateQ <= rawCompare ? StHigh : StLow;
                        end
                    end
                    StHigh: begin
                        if (!rawCompare) begin
                            stateQ     <= StDeadHl;
                            deadCountQ <= DeadLoad;
                        end
                    end
                    StLow: begin
                        if (rawCompare) begin
                            stateQ     <= StDeadLh;
                            deadCountQ <= DeadLoad;
                        end
                    end
                    StDeadHl, StDeadLh: begin
                        // Re-evaluate raw at expiry: a reverted compare returns to the
                        // original side, swallowing sub-dead-time pulses.
                        if (deadCountQ == 8'd0) begin
                            stateQ <= rawCompare ? StHigh : StLow;
                        end else begin
                            deadCountQ <= deadCountQ - 8'd1;
                        end
                    end
                    default: stateQ <= StIdle;
                endcase
            end
        end
    end

    assign pwmBus.HighSide    = highSideQ;
    assign pwmBus.LowSide     = lowSideQ;
    assign pwmBus.PeriodStart = periodStartQ;
    assign pwmBus.DutyLatched = dutyLatchedQ;

endmodule

// File: doc/motor_pwm_generator.md
# motor_pwm_generator

Converts the 12-bit motor drive command produced by the current-control loop into a complementary, dead-time-protected half-bridge gate pair. It sits directly downstream of the current controller: its duty input is wired to the controller's `MotorSignal`, and its outputs drive the gate-driver pins. The duty value is double-buffered and updated only at period boundaries, so a mid-period command change never produces a runt pulse.

## Interface
- `CounterMax`, 4095, PWM period in clocks; the counter runs 0..CounterMax-1; legal range 2..4095.
- `DeadTime`, 8, clocks with both gates off at every side change; legal range 1..255.
- `PwmClock`  in  1  single block clock; all logic is on its rising edge.
- `ResetN`  in  1  synchronous, active-low reset, sampled on `PwmClock` rising edge.
- `Enable`  in  1  run/stop; low forces both gates off.
- `DutyCycle`  in  12  unsigned on-time command in clocks (the controller's `MotorSignal`).
- `HighSide`  out  1  high-side gate, registered.
- `LowSide`  out  1  low-side gate, registered.
- `PeriodStart`  out  1  one-clock strobe, registered, high in the cycle where the counter equals 0.
- `DutyLatched`  out  12  duty value in effect for the current period.

## Operation
- **Period counter (12 bit):**
  - With `Enable`=1 it increments each clock and wraps from CounterMax-1 to 0.
  - With `Enable`=0 it is held at 0.
- **Duty buffer:**
  - On the edge where the counter wraps to 0, `DutyLatched` <= `DutyCycle`.
  - While `Enable`=0, `DutyLatched` <= `DutyCycle` every clock.
  - No other updates occur.
- **Raw compare:** raw = (Counter < DutyLatched), 12-bit unsigned.
  - `DutyLatched`=0 gives raw always 0.
  - `DutyLatched` >= CounterMax gives raw always 1, which is the clamp to 100%.
- **Gate FSM, states IDLE, HIGH, LOW, DEAD_HL, DEAD_LH:**
  - IDLE: both gates 0. With `Enable`=1, go to HIGH if raw=1, else LOW. No dead time applies, since both gates were already off.
  - HIGH: `HighSide`=1. If raw=0, go to DEAD_HL and load the dead counter with DeadTime-1.
  - LOW: `LowSide`=1. If raw=1, go to DEAD_LH and load the dead counter.
  - DEAD_HL / DEAD_LH: both gates 0; the dead counter decrements each clock. When it reaches 0 and is observed, go to HIGH if raw=1, else LOW.
  - Raw reverting during dead time therefore returns to the original side, and pulses shorter than DeadTime are swallowed.
  - `Enable`=0 from any state goes to IDLE on the next edge.
- **Invariant:** `HighSide` and `LowSide` are never 1 in the same cycle, including across reset, enable edges and duty changes.
- **Gate drive:** gate outputs are decoded from the registered state and held in output flops. No combinational path runs from inputs to outputs.

## Timing
- **Reset:** `ResetN`=0 at an edge gives, on that edge: counter=0, `DutyLatched`=0, FSM=IDLE, `HighSide`=0, `LowSide`=0, `PeriodStart`=0. This holds regardless of `Enable`, including mid-pulse.
- **First enabled cycle** (after reset release or an `Enable` rise):
  - Counter=0 and `PeriodStart`=1.
  - The FSM leaves IDLE on the following edge.
- **Compare-to-gate latency:** a raw transition at counter value k reaches the gate outputs at the edge closing cycle k+1.
- **Steady-state pulse widths** (0 < D < CounterMax, D > DeadTime, CounterMax-D > DeadTime):
  - `HighSide` high D-DeadTime clocks per period.
  - `LowSide` high CounterMax-D-DeadTime clocks per period.
  - Two dead windows of DeadTime clocks each.
  - Sum = CounterMax.
- **`PeriodStart`** period is exactly CounterMax clocks while enabled.
- **Duty change:** a `DutyCycle` change takes effect on the gates no earlier than the next `PeriodStart` plus one clock.
- **Enable drop:** `Enable`=0 gives both gates 0 at the next edge; no dead-time wait is required to turn off.

## Test plan
- **Reset mid-pulse:** run with D=2048, assert `ResetN`=0 for 3 clocks while `HighSide`=1 -> all outputs 0 after the first reset edge, `DutyLatched`=0. Release -> `PeriodStart`=1 in the first cycle.
- **50% duty:** D=2048, defaults -> per period `HighSide`=1 for 2040 clocks and `LowSide`=1 for 2039 clocks, two 8-clock all-off gaps, `PeriodStart` every 4095 clocks. Overlap checker never fires.
- **Extremes:**
  - D=0 -> `HighSide` constant 0, `LowSide` constant 1 after entry from IDLE.
  - D=4095 -> `HighSide` constant 1, `LowSide` constant 0, no dead windows.
- **Double buffering:** D=1000, change `DutyCycle` to 3000 at counter=1500 -> current period high time stays 992. `DutyLatched`=3000 in the next `PeriodStart` cycle; the next period has high time 2992.
- **Sub-dead-time pulse:** D=4, DeadTime=8 -> `HighSide` never asserts. `LowSide` drops for exactly 8 clocks starting one clock after each `PeriodStart`.
- **Enable toggle:** drop `Enable` while in HIGH -> both gates 0 next edge, counter held at 0. Re-raise -> `PeriodStart`=1 on the first enabled cycle and normal waveform resumes.
